// File: rtl/loop_scanner_if.sv
// Handshake bundle between the loop executor (master) and the bracket scanner (slave).
// When SCAN_STEP_COUNT_EN is defined, the bundle also carries the step counter.
interface loop_scanner_if #(
    parameter int DEPTH_W = 7
);
    logic               start;
    logic [3:0]         opcode;
    logic               data_zero;
    logic               ip_at_min;
    logic               ip_at_max;
    logic               ip_up;
    logic               ip_down;
    logic               busy;
    logic               done;
    logic               error;
    logic [DEPTH_W-1:0] loop_depth;
`ifdef SCAN_STEP_COUNT_EN
    logic [15:0]        step_count;

    modport master (
        output start, opcode, data_zero, ip_at_min, ip_at_max,
        input  ip_up, ip_down, busy, done, error, loop_depth, step_count
    );
    modport slave (
        input  start, opcode, data_zero, ip_at_min, ip_at_max,
        output ip_up, ip_down, busy, done, error, loop_depth, step_count
    );
`else
    modport master (
        output start, opcode, data_zero, ip_at_min, ip_at_max,
        input  ip_up, ip_down, busy, done, error, loop_depth
    );
    modport slave (
        input  start, opcode, data_zero, ip_at_min, ip_at_max,
        output ip_up, ip_down, busy, done, error, loop_depth
    );
`endif
endinterface

// File: rtl/loop_scanner.sv
// Bracket-matching scanner: walks the instruction pointer forward or backward one
// step at a time until the bracket matching the dispatched one is under IP.
// Optional macro SCAN_STEP_COUNT_EN adds a saturating 16-bit count of IP steps.
module loop_scanner #(
    parameter int         DEPTH_W       = 7,
    parameter int         MAX_DEPTH     = 100,
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] OP_OPEN       = 4'd5,
    parameter logic [3:0] OP_CLOSE      = 4'd6
) (
    input logic           clk,
    input logic           Rst,
    loop_scanner_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, FWD_STEP, FWD_WAIT, BWD_STEP, BWD_WAIT, DONE, ERR
    } state_t;

    localparam logic [DEPTH_W:0] MAX_D     = (DEPTH_W+1)'(MAX_DEPTH);
    localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYCLES);

    state_t             state;
    logic [DEPTH_W-1:0] depth;
    logic [3:0]         settle;
    logic               ip_up_q;
    logic               ip_down_q;
    logic               busy_q;
    logic               done_q;
    logic               error_q;

    // Direction-dependent views so both scan directions share one set of rules.
    logic       in_fwd;
    logic [3:0] deeper_op;
    logic [3:0] shallower_op;
    logic       at_edge;
    logic       depth_full;
    logic       fwd_jump;
    logic       bwd_jump;

    assign in_fwd       = (state == FWD_STEP) || (state == FWD_WAIT);
    assign deeper_op    = in_fwd ? OP_OPEN  : OP_CLOSE;
    assign shallower_op = in_fwd ? OP_CLOSE : OP_OPEN;
    assign at_edge      = in_fwd ? bus.ip_at_max : bus.ip_at_min;
    assign depth_full   = {1'b0, depth} >= MAX_D;
    assign fwd_jump     = (bus.opcode == OP_OPEN)  &&  bus.data_zero;
    assign bwd_jump     = (bus.opcode == OP_CLOSE) && !bus.data_zero;

    // Scan FSM with all outputs registered; pulse outputs default low every cycle.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state     <= IDLE;
            depth     <= '0;
            settle    <= '0;
            ip_up_q   <= 1'b0;
            ip_down_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every decision below sees the
            // register values from the start of this cycle, and the later
            // assignments in a branch override these pulse defaults.
            ip_up_q   <= 1'b0;
            ip_down_q <= 1'b0;
            done_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (fwd_jump || bwd_jump) begin
                            if ((fwd_jump && bus.ip_at_max) || (bwd_jump && bus.ip_at_min)) begin
                                state   <= ERR;
                                error_q <= 1'b1;
                            end else begin
                                depth     <= DEPTH_W'(1);
                                busy_q    <= 1'b1;
                                state     <= fwd_jump ? FWD_STEP : BWD_STEP;
                                ip_up_q   <= fwd_jump;
                                ip_down_q <= bwd_jump;
                            end
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                FWD_STEP, BWD_STEP: begin
                    settle <= SETTLE_LD;
                    state  <= in_fwd ? FWD_WAIT : BWD_WAIT;
                end
                FWD_WAIT, BWD_WAIT: begin
                    settle <= settle - 4'd1;
                    if (settle == 4'd1) begin
                        if (bus.opcode == shallower_op && depth == DEPTH_W'(1)) begin
                            depth  <= '0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else if ((bus.opcode == deeper_op && depth_full) || at_edge) begin
                            depth   <= '0;
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                            state   <= ERR;
                        end else begin
                            if (bus.opcode == deeper_op) begin
                                depth <= depth + DEPTH_W'(1);
                            end else if (bus.opcode == shallower_op) begin
                                depth <= depth - DEPTH_W'(1);
                            end
                            ip_up_q   <= in_fwd;
                            ip_down_q <= !in_fwd;
                            state     <= in_fwd ? FWD_STEP : BWD_STEP;
                        end
                    end
                end
                DONE: begin
                    depth <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= ERR;
                end
            endcase
        end
    end

    assign bus.ip_up      = ip_up_q;
    assign bus.ip_down    = ip_down_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.loop_depth = depth;

`ifdef SCAN_STEP_COUNT_EN
    logic [15:0] step_q;

    // Count IP steps of the current or last scan; cleared by an accepted start.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            step_q <= '0;
        end else if (state == IDLE && bus.start) begin
            step_q <= '0;
        end else if ((state == FWD_STEP || state == BWD_STEP) && step_q != 16'hFFFF) begin
            step_q <= step_q + 16'd1;
        end
    end

    assign bus.step_count = step_q;
`endif

endmodule
